bcd_digit_formatter: RTL and testbench
======================================

Name: bcd_digit_formatter

Overview:
- Downstream consumer of the anode driver's digit-select count `s`.
- Accepts a binary amount (credit, price or change) on a one-cycle load strobe and converts it to four BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Holds the converted digits in display registers and drives the active-low cathode pattern for the digit currently selected by `s`.
- Provides leading-zero blanking and an overflow indication.

Parameters:
- VALUE_W, 14, width of the binary input value.
- MAX_VALUE, 9999, largest displayable value; anything above is overflow.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- value  input  VALUE_W  binary amount to display, sampled on an accepted load.
- load  input  1  one-cycle strobe requesting conversion of `value`.
- blank_lz  input  1  1 = blank leading zeros on digits 3..1.
- s  input  2  digit select from the anode driver: 00 = digit0 (rightmost) .. 11 = digit3.
- seg  output  7  active-low cathodes, bit order {g,f,e,d,c,b,a}.
- busy  output  1  conversion in progress.
- done  output  1  one-cycle pulse when new digits are committed.
- ovf  output  1  displayed value is an overflow.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; shift register, iteration counter and display digits all 0.
  - busy=0, done=0, ovf=0.
  - seg follows `s` with digits=0000: shows "0" on digit0; digits 3..1 show "0", or are blank if blank_lz=1.
- FSM states:
  - IDLE: on load=1, capture `value` and move to CONVERT with counter=0; busy goes 1 at the same edge.
    - If value > MAX_VALUE, set an internal overflow flag; the conversion still runs its full length, so latency is constant.
  - CONVERT: one shift-add-3 iteration per clk. For each BCD nibble ≥5, add 3, then shift the whole register left by 1. Counter increments each cycle. After iteration VALUE_W (counter = VALUE_W-1 at the edge), go to COMMIT.
  - COMMIT: copy BCD nibbles to the display digit registers; ovf <= overflow flag; done=1 for exactly this cycle; busy=0. Return to IDLE next edge.
- Latency: load sampled at edge 0; iterations at edges 1..14; digits, ovf and done update at edge 15 (edge VALUE_W+1).
- busy is 1 from edge 0 through edge 15, then 0.
- load while busy=1 (CONVERT or COMMIT) is ignored; it is not queued.
- load in the cycle done=1 is ignored (state is COMMIT); load is accepted from the following cycle.
- The display registers keep the previous value for the entire conversion. No partial digits are ever visible.
- Cathode output:
  - seg is combinational from `s` and the display registers; it has no internal latency relative to `s`.
  - Font (active-low, {g..a}):
    - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
    - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Nibble >9 is unreachable; it must still decode to blank (1111111).
- Leading-zero blanking (blank_lz=1):
  - digit k (k=3..1) is blank if it and every digit above it are 0.
  - digit0 is never blanked.
- Overflow: when ovf=1, every digit shows "-" (0111111) regardless of blank_lz. This persists until a later in-range load commits.
- Reset mid-conversion aborts immediately: state=IDLE, all digits 0, ovf=0, no done pulse.
- value = 0 converts to 0000. value = MAX_VALUE converts to 9999 with ovf=0.

Test Plan:
- Reset release, blank_lz=0, cycle s 00..11 -> seg=1000000 on all four digits; busy=0, done=0, ovf=0.
- load with value=1234 -> busy high 15 cycles, done pulses at edge 15. s=00/01/10/11 gives seg=0011001/0110000/0100100/1111001. Before edge 15, seg still shows the old value.
- value=50, blank_lz=1 -> digit0=1000000, digit1=0010010, digits 2,3=1111111. With blank_lz=0, digits 2,3=1000000.
- value=12000 -> ovf=1 after edge 15, all digits 0111111. A following load of 9999 -> ovf=0, all digits 0010000.
- load 1234 then load 5678 at edge 5 -> 5678 ignored, 1234 committed. A load of 5678 issued after done is accepted and committed 15 cycles later.
- load 8888, assert reset at edge 7 -> digits 0000, busy=0, no done pulse. After release, a load of 42 converts normally.

Source files
------------

// File: rtl/bcd_digit_formatter.sv
// Binary-to-BCD display formatter: sequential double-dabble conversion into
// held display digits, driving active-low cathodes for the digit selected by s.

module bcd_digit_formatter_add3 (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);
  always_comb begin
    nib_o = nib_i;
    if (nib_i >= 4'd5) nib_o = nib_i + 4'd3;
  end
endmodule

module bcd_digit_formatter #(
  parameter int VALUE_W   = 14,
  parameter int MAX_VALUE = 9999
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [VALUE_W-1:0] value,
  input  logic               load,
  input  logic               blank_lz,
  input  logic [1:0]         s,
  output logic [6:0]         seg,
  output logic               busy,
  output logic               done,
  output logic               ovf
);
  localparam int NUM_DIGITS = 4;
  localparam int BCD_W      = 4 * NUM_DIGITS;
  localparam int SR_W       = BCD_W + VALUE_W;
  localparam int CNT_W      = $clog2(VALUE_W + 1);
  localparam logic [VALUE_W-1:0] MAX_V   = VALUE_W'(MAX_VALUE);
  localparam logic [CNT_W-1:0]   LAST_IT = CNT_W'(VALUE_W - 1);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

  state_t                             state_q, state_d;
  logic [SR_W-1:0]                    sr_q, sr_d, sr_adj;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic                               ovf_flag_q, ovf_flag_d;
  logic                               ovf_q, ovf_d;
  logic [NUM_DIGITS-1:0][3:0]         digits_q, digits_d;
  logic [NUM_DIGITS-1:0][3:0]         nib_adj;
  logic [NUM_DIGITS-1:0]              lz;
  logic [3:0]                         sel;

  // One add-3 lane per BCD nibble of the shift register.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lane
    bcd_digit_formatter_add3 u_add3 (
      .nib_i (sr_q[VALUE_W+4*i +: 4]),
      .nib_o (nib_adj[i])
    );
  end

  always_comb begin
    sr_adj = sr_q;
    sr_adj[SR_W-1:VALUE_W] = nib_adj;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = CONVERT;
      CONVERT: if (cnt_q == LAST_IT) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == COMMIT);
    ovf  = ovf_q;
  end

  always_comb begin
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    ovf_flag_d = ovf_flag_q;
    digits_d   = digits_q;
    ovf_d      = ovf_q;
    case (state_q)
      IDLE: if (load) begin
        sr_d       = {{BCD_W{1'b0}}, value};
        cnt_d      = '0;
        ovf_flag_d = (value > MAX_V);
      end
      CONVERT: begin
        sr_d  = {sr_adj[SR_W-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
      end
      COMMIT: begin
        digits_d = sr_q[SR_W-1:VALUE_W];
        ovf_d    = ovf_flag_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q       <= '0;
      cnt_q      <= '0;
      ovf_flag_q <= 1'b0;
      digits_q   <= '0;
      ovf_q      <= 1'b0;
    end else begin
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      ovf_flag_q <= ovf_flag_d;
      digits_q   <= digits_d;
      ovf_q      <= ovf_d;
    end
  end

  // lz[k]: digit k and every digit above it are zero; digit0 never blanks.
  always_comb begin
    lz[3] = (digits_q[3] == 4'd0);
    lz[2] = lz[3] && (digits_q[2] == 4'd0);
    lz[1] = lz[2] && (digits_q[1] == 4'd0);
    lz[0] = 1'b0;
  end

  always_comb begin
    sel = digits_q[s];
    seg = SEG_BLANK;
    if (ovf_q) begin
      seg = SEG_DASH;
    end else if (!(blank_lz && lz[s])) begin
      case (sel)
        4'd0:    seg = 7'b1000000;
        4'd1:    seg = 7'b1111001;
        4'd2:    seg = 7'b0100100;
        4'd3:    seg = 7'b0110000;
        4'd4:    seg = 7'b0011001;
        4'd5:    seg = 7'b0010010;
        4'd6:    seg = 7'b0000010;
        4'd7:    seg = 7'b1111000;
        4'd8:    seg = 7'b0000000;
        4'd9:    seg = 7'b0010000;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_digit_formatter.sv
// Scoreboard bench for bcd_digit_formatter: accepted loads queue their expected
// display value; a monitor checks latency and cathodes whenever done pulses.

module tb_bcd_digit_formatter;
  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] value;
  logic        load;
  logic        blank_lz = 1'b0;
  logic [1:0]  s = 2'd0;
  logic [6:0]  seg;
  logic        busy, done, ovf;

  bcd_digit_formatter #(.VALUE_W(14), .MAX_VALUE(9999)) dut (
    .clk(clk), .reset(reset), .value(value), .load(load), .blank_lz(blank_lz),
    .s(s), .seg(seg), .busy(busy), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int v; int edge_n; } exp_t;
  exp_t q[$];

  int checks = 0, errors = 0;
  bit have = 1'b0;
  int last = 0;
  int prev_val = 0;
  bit prev_ovf = 1'b0;
  bit rst_checked = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b expected=%0b", name, act, exp);
    end
  endtask

  // Reference display: decimal digit k of val, blanked when val < 10^k.
  function automatic logic [6:0] exp_seg(input int val, input bit ov, input int k, input bit blz);
    int p = 1;
    int d;
    for (int i = 0; i < k; i++) p *= 10;
    if (ov) return 7'b0111111;
    if (blz && k > 0 && val < p) return 7'b1111111;
    d = (val / p) % 10;
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;
      2: return 7'b0100100;  3: return 7'b0110000;
      4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;
      8: return 7'b0000000;  default: return 7'b0010000;
    endcase
  endfunction

  task automatic check_disp(input string tag, input int val, input bit ov, input bit both);
    for (int b = 0; b <= (both ? 1 : 0); b++) begin
      for (int k = 0; k < 4; k++) begin
        blank_lz = b[0];
        s = k[1:0];
        #1;
        chk($sformatf("%s_v%0d_d%0d_lz%0d", tag, val, k, b), {25'd0, seg}, {25'd0, exp_seg(val, ov, k, b[0])});
      end
    end
  endtask

  // Monitor: owns s/blank_lz, compares each done pulse with the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      prev_val = 0;
      prev_ovf = 1'b0;
      if (!rst_checked) begin
        rst_checked = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);
        check_disp("rst", 0, 1'b0, 1'b1);
      end
    end else begin
      rst_checked = 1'b0;
      if (done) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done actual=1 expected=0 cyc=%0d", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("done_latency", cyc, e.edge_n + 14);
          check_disp("hold", prev_val, prev_ovf, 1'b0);
          @(posedge clk); #1;
          prev_val = e.v;
          prev_ovf = (e.v > 9999);
          chk("ovf", ovf, prev_ovf);
          check_disp("commit", prev_val, prev_ovf, 1'b1);
        end
      end
    end
  end

  // busy covers edges 0..15 of an accepted load, done only the COMMIT cycle.
  always @(negedge clk) begin
    if (reset) begin
      chk("busy", busy, have && cyc >= last && cyc <= last + 14);
      chk("done", done, have && cyc == last + 14);
    end
  end

  // Called at a negedge; load is sampled at the next posedge.
  task automatic issue_load(input int v);
    int edge_n;
    value = v[13:0];
    load = 1'b1;
    edge_n = cyc + 1;
    if (!have || edge_n >= last + 16) begin
      have = 1'b1;
      last = edge_n;
      q.push_back('{v: v, edge_n: edge_n});
    end
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_edge(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    reset = 1'b0; load = 1'b0; value = '0;
    #36 reset = 1'b1;
    @(negedge clk);

    issue_load(1234);
    wait_edge(last + 4);
    issue_load(5678);            // lands on edge 5 of the conversion: ignored
    wait_edge(last + 15);
    issue_load(50);
    wait_edge(last + 15);
    issue_load(12000);
    wait_edge(last + 15);
    issue_load(9999);
    wait_edge(last + 15);
    issue_load(0);
    wait_edge(last + 14);
    issue_load(777);             // done cycle: ignored
    issue_load(5678);            // next cycle: accepted
    wait_edge(last + 15);

    issue_load(8888);
    wait_edge(last + 6);
    @(posedge clk); #1;          // just after edge 7
    reset = 1'b0;
    have = 1'b0;
    void'(q.pop_back());
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    issue_load(42);
    wait_edge(last + 15);

    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 20)) @(negedge clk);
      case ($urandom_range(0, 9))
        0:       v = $urandom_range(10000, 16383);
        1:       v = 9999;
        2:       v = $urandom_range(0, 9);
        default: v = $urandom_range(0, 9999);
      endcase
      issue_load(v);
    end

    wait_edge(last + 20);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
